can_trailer_sequencer: RTL
==========================

# can_trailer_sequencer

Tracks the CAN frame trailer (CRC delimiter, ACK slot, ACK delimiter, EOF, intermission) once the CRC field has been received. It checks the fixed-form bits and drives the active-low `EOF_Flag` that the downstream EOF error checker uses to locate the first EOF bit. It is clocked by the bit sample point `SP`, so one clock equals one CAN bit. It sits between the CRC receiver (upstream) and the EOF error checker / error-frame logic (downstream).

## Interface
Parameters:
- `EOF_BITS`, default 7: EOF length in bits.
- `INTER_BITS`, default 3: intermission length in bits.

Ports:
- `SP`, input, 1: clock, one rising edge per bit sample point.
- `reset`, input, 1: asynchronous, active-low reset.
- `RX`, input, 1: sampled bus level (0 = dominant, 1 = recessive).
- `CRC_End`, input, 1: high on the SP edge that samples the last CRC bit.
- `EOF_Flag`, output, 1: active-low. Low for exactly one SP period, during the first EOF bit.
- `CRC_Delim_Error`, output, 1: active-low, sticky; CRC delimiter sampled dominant.
- `ACK_Error`, output, 1: active-low, sticky; ACK slot sampled recessive.
- `ACK_Delim_Error`, output, 1: active-low, sticky; ACK delimiter sampled dominant.
- `Overload_Req`, output, 1: active-low one-bit pulse; dominant bit in intermission bit 0 or 1.
- `Frame_Done`, output, 1: active-high one-bit pulse after the last intermission bit.
- `Busy`, output, 1: high whenever the state is not IDLE.

## Operation
- The state names the field whose bit is sampled at the next SP edge.
- States are IDLE → CRC_DEL → ACK_SLOT → ACK_DEL → EOF → INTER → IDLE. Each transition happens on an SP edge.
- A 4-bit counter `cnt` is used in EOF and INTER and is cleared on every state entry.
- **IDLE:**
  - On an edge with `CRC_End`=1, go to CRC_DEL.
  - On the same edge, set all sticky errors to 1 (start of new trailer).
- **CRC_DEL:** if RX=0, drive `CRC_Delim_Error` to 0. Always go to ACK_SLOT; form errors never abort the sequence.
- **ACK_SLOT:** if RX=1, drive `ACK_Error` to 0. Go to ACK_DEL.
- **ACK_DEL:**
  - If RX=0, drive `ACK_Delim_Error` to 0.
  - Go to EOF and register `EOF_Flag` to 0 on this same edge.
- **EOF:**
  - `EOF_Flag` returns to 1 on the first edge in EOF (cnt 0→1).
  - RX is not checked here; checking is the downstream block's job.
  - At cnt=`EOF_BITS`-1, go to INTER.
- **INTER:**
  - If RX=0 at cnt 0 or 1, pulse `Overload_Req` to 0 for one SP period.
  - A dominant bit at cnt 2 is ignored (treated as SOF by the frame receiver).
  - At cnt=`INTER_BITS`-1, go to IDLE and pulse `Frame_Done` to 1 for one SP period.
- `CRC_End` outside IDLE is ignored.
- Sticky errors hold their value through IDLE until the next accepted `CRC_End`.
- `cnt` never wraps: the maximum value reached is `max(EOF_BITS, INTER_BITS)`-1 < 16.

## Timing
- **Reset value** (asynchronous, while `reset`=0):
  - state IDLE, `cnt`=0.
  - `EOF_Flag`=1, all error outputs=1, `Overload_Req`=1, `Frame_Done`=0, `Busy`=0.
- All outputs are registered and change only on an SP edge or on reset assertion.
- **Latency from the `CRC_End` edge (edge E):**
  - E+1 samples the CRC delimiter; `CRC_Delim_Error` is valid after E+1.
  - E+2 samples the ACK slot; `ACK_Error` is valid after E+2.
  - E+3 samples the ACK delimiter; `ACK_Delim_Error` is valid and `EOF_Flag`=0 after E+3.
  - E+4 samples EOF bit 1 with `EOF_Flag`=0 still visible; `EOF_Flag`=1 after E+4.
  - E+10 samples EOF bit 7.
  - E+11..E+13 sample the intermission bits; `Frame_Done`=1 after E+13 and 0 after E+14.
- Total trailer length: 13 SP edges with default parameters.
- Reset asserted mid-sequence: immediate return to the reset values. No `Frame_Done` is issued.
- Reset released on the same edge as `CRC_End`=1: the edge is honoured only if `reset` was already 1 before that edge.

## Test plan
- **Clean trailer:** `CRC_End` at edge 0; RX = 1,0,1 then 1×7 then 1×3.
  - Expect all errors=1 and `EOF_Flag`=0 only between edges 3 and 4.
  - Expect `Frame_Done`=1 only between edges 13 and 14, and `Busy`=0 after edge 13.
- **Missing ACK:** RX=1 in the ACK slot (edge 2).
  - Expect `ACK_Error`=0 after edge 2, held through IDLE.
  - Expect it to clear to 1 on the next `CRC_End` edge.
- **Delimiter faults:** RX=0 at edge 1 and at edge 3.
  - Expect `CRC_Delim_Error`=0 and `ACK_Delim_Error`=0.
  - Expect the sequence to continue and `Frame_Done` still to pulse after edge 13.
- **Overload:** RX=0 at intermission bit 0 (edge 11).
  - Expect `Overload_Req`=0 only between edges 11 and 12.
  - Expect RX=0 at edge 13 to produce no pulse.
- **Reset mid-EOF:** assert `reset`=0 asynchronously between edges 6 and 7.
  - Expect all outputs at their reset values immediately and no `Frame_Done`.
  - Expect a following `CRC_End` to restart cleanly.
- **Spurious `CRC_End`:** hold `CRC_End`=1 during edges 1–12.
  - Expect the timing to be identical to the clean trailer, with no restart.

Source files
------------

// File: rtl/can_trailer_sequencer.sv
// CAN frame trailer sequencer: walks CRC delimiter, ACK slot/delimiter, EOF and
// intermission one bit per SP edge, flagging form errors and marking the first EOF bit.
module can_trailer_sequencer #(
  parameter int EOF_BITS   = 7,
  parameter int INTER_BITS = 3
) (
  input  logic SP,
  input  logic reset,
  input  logic RX,
  input  logic CRC_End,
  output logic EOF_Flag,
  output logic CRC_Delim_Error,
  output logic ACK_Error,
  output logic ACK_Delim_Error,
  output logic Overload_Req,
  output logic Frame_Done,
  output logic Busy
);

  typedef enum logic [2:0] {
    IDLE,
    CRC_DEL,
    ACK_SLOT,
    ACK_DEL,
    EOF,
    INTER
  } state_t;

  localparam logic [3:0] EOF_LAST   = 4'(EOF_BITS - 1);
  localparam logic [3:0] INTER_LAST = 4'(INTER_BITS - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       eof_flag_reg, eof_flag_next;
  logic [2:0] err_reg, err_next;  // [0] CRC delimiter, [1] ACK slot, [2] ACK delimiter
  logic       overload_reg, overload_next;
  logic       done_reg, done_next;
  logic       busy_reg, busy_next;

  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      eof_flag_reg <= 1'b1;
      err_reg      <= 3'b111;
      overload_reg <= 1'b1;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      eof_flag_reg <= eof_flag_next;
      err_reg      <= err_next;
      overload_reg <= overload_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    eof_flag_next = 1'b1;
    err_next      = err_reg;
    overload_next = 1'b1;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (CRC_End) begin
          state_next = CRC_DEL;
          cnt_next   = 4'd0;
          err_next   = 3'b111;
        end
      end
      CRC_DEL: begin
        if (!RX) err_next[0] = 1'b0;
        state_next = ACK_SLOT;
        cnt_next   = 4'd0;
      end
      ACK_SLOT: begin
        if (RX) err_next[1] = 1'b0;
        state_next = ACK_DEL;
        cnt_next   = 4'd0;
      end
      ACK_DEL: begin
        if (!RX) err_next[2] = 1'b0;
        state_next    = EOF;
        cnt_next      = 4'd0;
        eof_flag_next = 1'b0;
      end
      EOF: begin
        if (cnt_reg == EOF_LAST) begin
          state_next = INTER;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      INTER: begin
        // A dominant third intermission bit is a new SOF, not an overload.
        if ((cnt_reg <= 4'd1) && !RX) overload_next = 1'b0;
        if (cnt_reg == INTER_LAST) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign EOF_Flag        = eof_flag_reg;
  assign CRC_Delim_Error = err_reg[0];
  assign ACK_Error       = err_reg[1];
  assign ACK_Delim_Error = err_reg[2];
  assign Overload_Req    = overload_reg;
  assign Frame_Done      = done_reg;
  assign Busy            = busy_reg;

endmodule
